// File: rtl/scr1_mem_ahb_pkg.sv
// Shared AHB-Lite constants, core memory interface types and lane helpers
// for the core-memory to AHB-Lite master bridge.
package scr1_mem_ahb_pkg;

    localparam int SCR1_AHB_WIDTH = 32;

    // AHB-Lite encodings
    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] SCR1_HSIZE_8B      = 3'b000;
    localparam logic [2:0] SCR1_HSIZE_16B     = 3'b001;
    localparam logic [2:0] SCR1_HSIZE_32B     = 3'b010;
    localparam logic [2:0] SCR1_HBURST_SINGLE = 3'b000;
    localparam logic       SCR1_HRESP_OKAY    = 1'b0;
    localparam logic       SCR1_HRESP_ERROR   = 1'b1;
    localparam int         SCR1_HPROT_DATA    = 0;

    // Core memory interface
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // Queued request, as accepted from the core
    typedef struct packed {
        type_scr1_mem_cmd_e          cmd;
        type_scr1_mem_width_e        width;
        logic [SCR1_AHB_WIDTH-1:0]   addr;
        logic [SCR1_AHB_WIDTH-1:0]   wdata;
    } type_scr1_ahb_req_s;

    // What the data phase still needs once the address phase has gone out
    typedef struct packed {
        type_scr1_mem_cmd_e          cmd;
        type_scr1_mem_width_e        width;
        logic [1:0]                  addr_lo;
        logic [SCR1_AHB_WIDTH-1:0]   wdata;
    } type_scr1_ahb_dp_s;

    typedef enum logic {
        SCR1_FSM_ADDR = 1'b0,
        SCR1_FSM_DATA = 1'b1
    } type_scr1_ahb_state_e;

    function automatic logic [2:0] scr1_width2hsize(input type_scr1_mem_width_e w);
        case (w)
            SCR1_MEM_WIDTH_BYTE:  return SCR1_HSIZE_8B;
            SCR1_MEM_WIDTH_HWORD: return SCR1_HSIZE_16B;
            default:              return SCR1_HSIZE_32B;
        endcase
    endfunction

    // Replicate LSB-aligned write data onto every byte lane it may land on
    function automatic logic [SCR1_AHB_WIDTH-1:0] scr1_lane_wdata(
        input type_scr1_mem_width_e      w,
        input logic [SCR1_AHB_WIDTH-1:0] d
    );
        case (w)
            SCR1_MEM_WIDTH_BYTE:  return {4{d[7:0]}};
            SCR1_MEM_WIDTH_HWORD: return {2{d[15:0]}};
            default:              return d;
        endcase
    endfunction

    // Move the addressed lane down to bit 0 and zero everything above it
    function automatic logic [SCR1_AHB_WIDTH-1:0] scr1_lane_rdata(
        input type_scr1_mem_width_e      w,
        input logic [1:0]                lo,
        input logic [SCR1_AHB_WIDTH-1:0] d
    );
        logic [SCR1_AHB_WIDTH-1:0] s;
        s = d >> {lo, 3'b000};
        case (w)
            SCR1_MEM_WIDTH_BYTE:  return {24'h0, s[7:0]};
            SCR1_MEM_WIDTH_HWORD: return {16'h0, s[15:0]};
            default:              return s;
        endcase
    endfunction

endpackage

// File: rtl/scr1_mem_ahb_req_fifo.sv
// Request FIFO for the AHB bridge: registered head (not fall-through),
// DEPTH entries (1..8), pointers and count reset, storage not reset.
module scr1_ahb_req_fifo
    import scr1_mem_ahb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = type_scr1_ahb_req_s
) (
    input  logic   rst_n,
    input  logic   clk,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage
    // NOTE: the array carries no reset; count/empty guard every read, so a
    // reset here would only add a reset net to every storage bit.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

`ifdef SCR1_SYN_OFF_EN
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
`endif

endmodule

// File: rtl/scr1_mem_ahb.sv
// Core-memory to AHB-Lite master bridge: queued requests, pipelined
// address/data phases, lane steering and optional registered response.
module scr1_mem_ahb
    import scr1_mem_ahb_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH = 2,
    parameter bit RESP_REG       = 1'b0
) (
    input  logic                      rst_n,
    input  logic                      clk,
    // Core side
    output logic                      req_ack,
    input  logic                      req,
    input  type_scr1_mem_cmd_e        cmd,
    input  type_scr1_mem_width_e      width,
    input  logic [SCR1_AHB_WIDTH-1:0] addr,
    input  logic [SCR1_AHB_WIDTH-1:0] wdata,
    output logic [SCR1_AHB_WIDTH-1:0] rdata,
    output type_scr1_mem_resp_e       resp,
    // AHB-Lite side
    output logic [3:0]                hprot,
    output logic [2:0]                hburst,
    output logic [2:0]                hsize,
    output logic [1:0]                htrans,
    output logic                      hmastlock,
    output logic [SCR1_AHB_WIDTH-1:0] haddr,
    output logic                      hwrite,
    output logic [SCR1_AHB_WIDTH-1:0] hwdata,
    input  logic                      hready,
    input  logic [SCR1_AHB_WIDTH-1:0] hrdata,
    input  logic                      hresp
);

    type_scr1_ahb_req_s        push_entry;
    type_scr1_ahb_req_s        head;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    type_scr1_ahb_state_e      state;
    type_scr1_ahb_state_e      state_next;
    type_scr1_ahb_dp_s         dp;
    type_scr1_mem_resp_e       resp_comb;
    logic [SCR1_AHB_WIDTH-1:0] rdata_comb;

    assign req_ack    = ~fifo_full;
    assign fifo_push  = req & ~fifo_full;
    assign push_entry = '{cmd: cmd, width: width, addr: addr, wdata: wdata};

    scr1_ahb_req_fifo #(
        .DEPTH   (REQ_FIFO_DEPTH),
        .entry_t (type_scr1_ahb_req_s)
    ) u_req_fifo (
        .rst_n     (rst_n),
        .clk       (clk),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SCR1_FSM_ADDR;
        else        state <= state_next;
    end

    // FSM next state: an ERROR completion always drops back to ADDR
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            SCR1_FSM_ADDR: if (!fifo_empty) state_next = SCR1_FSM_DATA;
            SCR1_FSM_DATA: begin
                if (hready && (hresp == SCR1_HRESP_ERROR || fifo_empty))
                    state_next = SCR1_FSM_ADDR;
            end
            default: state_next = SCR1_FSM_ADDR;
        endcase
    end

    // FSM outputs: address phase from the FIFO head, pop when it is accepted
    always_comb begin
        htrans    = SCR1_HTRANS_IDLE;
        fifo_pop  = 1'b0;
        resp_comb = SCR1_MEM_RESP_NOTRDY;
        case (state)
            SCR1_FSM_ADDR: begin
                if (!fifo_empty) begin
                    htrans   = SCR1_HTRANS_NONSEQ;
                    fifo_pop = 1'b1;
                end
            end
            SCR1_FSM_DATA: begin
                // Next address is held on the bus through wait states but
                // withdrawn while the slave is signalling ERROR
                if (!fifo_empty && hresp == SCR1_HRESP_OKAY) begin
                    htrans   = SCR1_HTRANS_NONSEQ;
                    fifo_pop = hready;
                end
                if (hready)
                    resp_comb = (hresp == SCR1_HRESP_ERROR) ? SCR1_MEM_RESP_RDY_ER
                                                            : SCR1_MEM_RESP_RDY_OK;
            end
            default: ;
        endcase
    end

    assign haddr     = fifo_empty ? '0 : head.addr;
    assign hwrite    = ~fifo_empty & (head.cmd == SCR1_MEM_CMD_WR);
    assign hsize     = fifo_empty ? SCR1_HSIZE_8B : scr1_width2hsize(head.width);
    assign hburst    = SCR1_HBURST_SINGLE;
    assign hmastlock = 1'b0;

    always_comb begin
        hprot                  = '0;
        hprot[SCR1_HPROT_DATA] = ~fifo_empty;
    end

    // Data-phase context, captured as the address phase is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp <= '0;
        end else if (fifo_pop) begin
            dp <= '{cmd: head.cmd, width: head.width,
                    addr_lo: head.addr[1:0], wdata: head.wdata};
        end
    end

    assign hwdata     = scr1_lane_wdata(dp.width, dp.wdata);
    assign rdata_comb = (dp.cmd == SCR1_MEM_CMD_RD) ? scr1_lane_rdata(dp.width, dp.addr_lo, hrdata)
                                                    : '0;

    generate
        if (RESP_REG) begin : g_resp_reg
            type_scr1_mem_resp_e       resp_q;
            logic [SCR1_AHB_WIDTH-1:0] rdata_q;

            // Registered response: resp and rdata one cycle after the data phase
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    resp_q  <= SCR1_MEM_RESP_NOTRDY;
                    rdata_q <= '0;
                end else begin
                    resp_q  <= resp_comb;
                    rdata_q <= rdata_comb;
                end
            end

            assign resp  = resp_q;
            assign rdata = rdata_q;
        end else begin : g_resp_comb
            assign resp  = resp_comb;
            assign rdata = rdata_comb;
        end
    endgenerate

`ifdef SCR1_SYN_OFF_EN
    a_x_req:    assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req));
    a_x_hready: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(hready));
    a_x_hresp:  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(hresp));
    a_align:    assert property (@(posedge clk) disable iff (!rst_n)
                    req |-> !((width == SCR1_MEM_WIDTH_HWORD && addr[0]) ||
                              (width == SCR1_MEM_WIDTH_WORD  && addr[1:0] != 2'b00)));
`endif

endmodule

// File: tb/tb_scr1_mem_ahb.sv
// Bench for scr1_mem_ahb: two instances (DEPTH=2/comb response and
// DEPTH=1/registered response), directed requests, scoreboarded responses.
module tb_scr1_mem_ahb;
    import scr1_mem_ahb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic hready = 1'b1;
    logic hresp  = 1'b0;

    // Instance 0: DEPTH=2, combinational response
    logic                 req0 = 1'b0;
    type_scr1_mem_cmd_e   cmd0 = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e width0 = SCR1_MEM_WIDTH_WORD;
    logic [31:0]          addr0 = '0, wdata0 = '0;
    logic                 req_ack0, hmastlock0, hwrite0;
    logic [31:0]          rdata0, haddr0, hwdata0, hrdata0;
    type_scr1_mem_resp_e  resp0;
    logic [3:0]           hprot0;
    logic [2:0]           hburst0, hsize0;
    logic [1:0]           htrans0;

    // Instance 1: DEPTH=1, registered response
    logic                 req1 = 1'b0;
    type_scr1_mem_cmd_e   cmd1 = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e width1 = SCR1_MEM_WIDTH_WORD;
    logic [31:0]          addr1 = '0, wdata1 = '0;
    logic                 req_ack1, hmastlock1, hwrite1;
    logic [31:0]          rdata1, haddr1, hwdata1, hrdata1;
    type_scr1_mem_resp_e  resp1;
    logic [3:0]           hprot1;
    logic [2:0]           hburst1, hsize1;
    logic [1:0]           htrans1;

    scr1_mem_ahb #(.REQ_FIFO_DEPTH(2), .RESP_REG(1'b0)) u_dut0 (
        .rst_n(rst_n), .clk(clk), .req_ack(req_ack0), .req(req0), .cmd(cmd0),
        .width(width0), .addr(addr0), .wdata(wdata0), .rdata(rdata0), .resp(resp0),
        .hprot(hprot0), .hburst(hburst0), .hsize(hsize0), .htrans(htrans0),
        .hmastlock(hmastlock0), .haddr(haddr0), .hwrite(hwrite0), .hwdata(hwdata0),
        .hready(hready), .hrdata(hrdata0), .hresp(hresp)
    );

    scr1_mem_ahb #(.REQ_FIFO_DEPTH(1), .RESP_REG(1'b1)) u_dut1 (
        .rst_n(rst_n), .clk(clk), .req_ack(req_ack1), .req(req1), .cmd(cmd1),
        .width(width1), .addr(addr1), .wdata(wdata1), .rdata(rdata1), .resp(resp1),
        .hprot(hprot1), .hburst(hburst1), .hsize(hsize1), .htrans(htrans1),
        .hmastlock(hmastlock1), .haddr(haddr1), .hwrite(hwrite1), .hwdata(hwdata1),
        .hready(hready), .hrdata(hrdata1), .hresp(hresp)
    );

    // Slave memory contents, by word address
    function automatic logic [31:0] slv_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        case (wa)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0010: return 32'hABCD_1234;
            default:       return 32'hC0DE_0000 | wa;
        endcase
    endfunction

    // Zero-wait slave: latch the accepted address, return data in the data phase
    logic [31:0] dp0, dp1;
    int          nacc0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp0   <= '0;
            dp1   <= '0;
            nacc0 <= 0;
        end else if (hready) begin
            if (htrans0 == SCR1_HTRANS_NONSEQ) begin
                dp0   <= haddr0;
                nacc0 <= nacc0 + 1;
            end
            if (htrans1 == SCR1_HTRANS_NONSEQ) dp1 <= haddr1;
        end
    end
    assign hrdata0 = slv_word(dp0);
    assign hrdata1 = slv_word(dp1);

    typedef struct {
        string               name;
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
        bit                  chk_rdata;
        int                  cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input int d, input string nm, input type_scr1_mem_resp_e r,
                               input logic [31:0] rd, input bit chk, input int c);
        exp_t e;
        e.name = nm; e.resp = r; e.rdata = rd; e.chk_rdata = chk; e.cyc = c;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Pop the oldest expectation for an instance and compare it
    task automatic score(input int d, input type_scr1_mem_resp_e r, input logic [31:0] rd);
        exp_t e;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_resp dut%0d: got %0d expected none at cycle %0d", d, r, cyc);
            return;
        end
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check({e.name, "_resp"}, 32'(r), 32'(e.resp));
        if (e.chk_rdata) check({e.name, "_rdata"}, rd, e.rdata);
        if (e.cyc >= 0)  check({e.name, "_cycle"}, cyc, e.cyc);
    endtask

    // Monitor: any non-NOTRDY response is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp0 != SCR1_MEM_RESP_NOTRDY) score(0, resp0, rdata0);
            if (resp1 != SCR1_MEM_RESP_NOTRDY) score(1, resp1, rdata1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put0(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                        input logic [31:0] a, input logic [31:0] wd);
        req0 = 1'b1; cmd0 = c; width0 = w; addr0 = a; wdata0 = wd;
    endtask

    task automatic put1(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                        input logic [31:0] a, input logic [31:0] wd);
        req1 = 1'b1; cmd1 = c; width1 = w; addr1 = a; wdata1 = wd;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_start;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_htrans0",  htrans0, SCR1_HTRANS_IDLE);
        check("rst_haddr0",   haddr0, 32'h0);
        check("rst_hwrite0",  hwrite0, 1'b0);
        check("rst_resp0",    resp0, SCR1_MEM_RESP_NOTRDY);
        check("rst_req_ack0", req_ack0, 1'b1);
        check("rst_htrans1",  htrans1, SCR1_HTRANS_IDLE);
        check("rst_resp1",    resp1, SCR1_MEM_RESP_NOTRDY);
        check("rst_req_ack1", req_ack1, 1'b1);
        rst_n = 1'b1;
        tick();

        // S1: WORD read 0x100, zero wait: NONSEQ in cycle 1, resp in cycle 2
        put0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
        expect_resp(0, "s1_rd", SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF, 1'b1, cyc + 2);
        tick(); req0 = 1'b0;
        @(negedge clk);
        check("s1_htrans",    htrans0, SCR1_HTRANS_NONSEQ);
        check("s1_haddr",     haddr0, 32'h100);
        check("s1_hsize",     hsize0, SCR1_HSIZE_32B);
        check("s1_hwrite",    hwrite0, 1'b0);
        check("s1_hprot",     hprot0, 4'b0001);
        check("s1_hburst",    hburst0, SCR1_HBURST_SINGLE);
        check("s1_hmastlock", hmastlock0, 1'b0);
        tick(); tick();

        // S2: BYTE write 0x203 / 0x5A, replicated on all lanes
        put0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h203, 32'h5A);
        expect_resp(0, "s2_wr", SCR1_MEM_RESP_RDY_OK, 32'h0, 1'b0, cyc + 2);
        tick(); req0 = 1'b0;
        @(negedge clk);
        check("s2_htrans", htrans0, SCR1_HTRANS_NONSEQ);
        check("s2_haddr",  haddr0, 32'h203);
        check("s2_hsize",  hsize0, SCR1_HSIZE_8B);
        check("s2_hwrite", hwrite0, 1'b1);
        tick();
        @(negedge clk);
        check("s2_hwdata", hwdata0, 32'h5A5A_5A5A);
        tick();

        // S3: reads 0x0, 0x4, 0x8 with two wait states on the first
        n_start = nacc0;
        put0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
        expect_resp(0, "s3_rd0", SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0000, 1'b1, -1);
        tick();
        put0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h0);
        expect_resp(0, "s3_rd4", SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0004, 1'b1, -1);
        @(negedge clk);
        check("s3_a0_haddr", haddr0, 32'h0);
        tick();
        put0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h8, 32'h0);
        expect_resp(0, "s3_rd8", SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0008, 1'b1, -1);
        hready = 1'b0;
        @(negedge clk);
        check("s3_w1_htrans", htrans0, SCR1_HTRANS_NONSEQ);
        check("s3_w1_haddr",  haddr0, 32'h4);
        tick();
        req0 = 1'b0;
        @(negedge clk);
        check("s3_full_req_ack", req_ack0, 1'b0);
        check("s3_w2_htrans",    htrans0, SCR1_HTRANS_NONSEQ);
        check("s3_w2_haddr",     haddr0, 32'h4);
        tick();
        hready = 1'b1;
        @(negedge clk);
        check("s3_a4_haddr", haddr0, 32'h4);
        tick();
        @(negedge clk);
        check("s3_a8_haddr",  haddr0, 32'h8);
        check("s3_a8_htrans", htrans0, SCR1_HTRANS_NONSEQ);
        tick();
        @(negedge clk);
        check("s3_idle_htrans", htrans0, SCR1_HTRANS_IDLE);
        tick();
        check("s3_nonseq_count", nacc0 - n_start, 3);

        // S4: HWORD read 0x12 picks the upper half of 0xABCD1234
        put0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, 32'h0);
        expect_resp(0, "s4_hw", SCR1_MEM_RESP_RDY_OK, 32'h0000_ABCD, 1'b1, cyc + 2);
        tick(); req0 = 1'b0;
        @(negedge clk);
        check("s4_hsize", hsize0, SCR1_HSIZE_16B);
        tick(); tick();

        // S5: ERROR on the first of two queued reads
        put0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0);
        expect_resp(0, "s5_err", SCR1_MEM_RESP_RDY_ER, 32'h0, 1'b0, -1);
        tick();
        put0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h24, 32'h0);
        expect_resp(0, "s5_ok", SCR1_MEM_RESP_RDY_OK, 32'hC0DE_0024, 1'b1, -1);
        @(negedge clk);
        check("s5_a20_haddr", haddr0, 32'h20);
        tick();
        req0  = 1'b0;
        hresp = 1'b1;
        @(negedge clk);
        check("s5_err_htrans", htrans0, SCR1_HTRANS_IDLE);
        tick();
        hresp = 1'b0;
        @(negedge clk);
        check("s5_retry_htrans", htrans0, SCR1_HTRANS_NONSEQ);
        check("s5_retry_haddr",  haddr0, 32'h24);
        tick(); tick();

        // S6: DEPTH=1, registered response lands in cycle 3
        put1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
        expect_resp(1, "s6_rd", SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF, 1'b1, cyc + 3);
        tick(); req1 = 1'b0;
        @(negedge clk);
        check("s6_htrans",       htrans1, SCR1_HTRANS_NONSEQ);
        check("s6_haddr",        haddr1, 32'h100);
        check("s6_full_req_ack", req_ack1, 1'b0);
        tick(); tick(); tick();

        // S7: reset pulsed during a held data phase; no response may follow
        put1(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, 32'h0);
        tick(); req1 = 1'b0;
        tick();
        hready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s7_rst_htrans",  htrans1, SCR1_HTRANS_IDLE);
        check("s7_rst_resp",    resp1, SCR1_MEM_RESP_NOTRDY);
        check("s7_rst_req_ack", req_ack1, 1'b1);
        check("s7_rst_haddr",   haddr1, 32'h0);
        tick();
        rst_n  = 1'b1;
        hready = 1'b1;
        tick(); tick(); tick();
        check("s7_post_htrans", htrans1, SCR1_HTRANS_IDLE);
        check("s7_post_resp",   resp1, SCR1_MEM_RESP_NOTRDY);

        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
